// File: rtl/apb_mem_slave_pkg.sv
// apb_mem_slave_pkg
//   Shared types and constants for the APB4 memory slave.
//   - apb_state_e : bus phase of the slave (IDLE, SETUP, ACCESS)
//   - APB_OKAY / APB_SLVERR : pslverr encodings
//   - WAIT_CNT_W : width of the wait-state counter (0..15 wait states)
//   - addr_lsb() : number of byte-offset address bits for a data width
`timescale 1ns/1ps
package apb_mem_slave_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  localparam logic APB_OKAY   = 1'b0;
  localparam logic APB_SLVERR = 1'b1;

  localparam int WAIT_CNT_W = 4;

  function automatic int addr_lsb(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/apb_mem_slave_if.sv
// apb_mem_slave_if
//   APB4 bus bundle between an APB master and the memory slave.
//   Parameters: ADDR_W (byte address width), DATA_W (data width).
//   Signals: psel, penable, pwrite, paddr, pwdata, pstrb (master -> slave),
//            pready, prdata, pslverr (slave -> master).
//   Modports: master, slave.
`timescale 1ns/1ps
interface apb_mem_slave_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_W-1:0]     paddr;
  logic [DATA_W-1:0]     pwdata;
  logic [DATA_W/8-1:0]   pstrb;
  logic                  pready;
  logic [DATA_W-1:0]     prdata;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output pready, prdata, pslverr
  );

endinterface

// File: rtl/apb_mem_slave_ram.sv
// apb_mem_slave_ram
//   Single-port synchronous RAM, DEPTH x DATA_W, per-byte write enables and a
//   registered read port with synchronous clear.
//   Ports:
//     clk   in  clock, rising edge
//     addr  in  word address (shared by read and write)
//     we    in  per-byte write enables
//     re    in  load read register from mem[addr]
//     clr   in  clear read register (wins over re)
//     wdata in  write data
//     rdata out registered read data
//   Contents start at MEM_INIT in simulation; nothing in here resets the array.
`timescale 1ns/1ps
module apb_mem_slave_ram #(
  parameter int                DEPTH    = 1024,
  parameter int                DATA_W   = 32,
  parameter int                AW       = 10,
  parameter logic [DATA_W-1:0] MEM_INIT = {(DATA_W/8){8'hCA}}
) (
  input  logic                clk,
  input  logic [AW-1:0]       addr,
  input  logic [DATA_W/8-1:0] we,
  input  logic                re,
  input  logic                clr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  localparam int STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH] = '{default: MEM_INIT};

  // Byte-lane writes: only lanes with their enable set are updated.
  always_ff @(posedge clk) begin
    for (int b = 0; b < STRB_W; b++) begin
      if (we[b]) begin
        mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Registered read; the clear lets the owner force prdata to zero on reset
  // and on rejected reads without touching the array.
  always_ff @(posedge clk) begin
    if (clr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/apb_mem_slave.sv
// apb_mem_slave
//   APB4 memory-mapped slave: word-organised RAM with byte strobes,
//   programmable wait states and PSLVERR on out-of-range or unaligned access.
//   Ports:
//     clk    in  clock, rising edge
//     reset  in  synchronous, active-high; aborts any transfer, memory kept
//     bus    slave modport of apb_mem_slave_if (psel, penable, pwrite, paddr,
//            pwdata, pstrb in; pready, prdata, pslverr out, all registered)
//   A transfer takes 2 + WAIT_STATES cycles. Read data is fetched on the edge
//   that ends the setup cycle; writes commit on the edge that ends the
//   pready cycle.
`timescale 1ns/1ps
module apb_mem_slave
  import apb_mem_slave_pkg::*;
#(
  parameter int                ADDR_W      = 12,
  parameter int                DATA_W      = 32,
  parameter int                DEPTH       = 1024,
  parameter int                WAIT_STATES = 0,
  parameter logic [DATA_W-1:0] MEM_INIT    = {(DATA_W/8){8'hCA}}
) (
  input logic           clk,
  input logic           reset,
  apb_mem_slave_if.slave bus
);

  localparam int LSB         = addr_lsb(DATA_W);
  localparam int IDX_W       = ADDR_W - LSB;
  localparam int IDX_EXT_W   = IDX_W + 1;
  localparam int STRB_W      = DATA_W / 8;
  localparam int RAM_AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0]     ALIGN_MASK = ADDR_W'((1 << LSB) - 1);
  localparam logic [IDX_EXT_W-1:0]  IDX_LIMIT  = IDX_EXT_W'(DEPTH);
  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT  = WAIT_CNT_W'(WAIT_STATES);
  localparam logic                  NO_WAIT    = (WAIT_STATES == 0);

  if (!(DATA_W == 8 || DATA_W == 16 || DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
    $error("apb_mem_slave: DATA_W must be 8, 16, 32 or 64");
  end
  if (longint'(DEPTH) * STRB_W > (longint'(1) << ADDR_W)) begin : g_bad_depth
    $error("apb_mem_slave: DEPTH too large for ADDR_W");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
    $error("apb_mem_slave: WAIT_STATES must be 0..15");
  end

  apb_state_e              state_q, state_d, phase;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    pready_q, pready_d;
  logic                    pslverr_q, pslverr_d;
  logic [RAM_AW-1:0]       idx_q, idx_d;
  logic                    write_q, write_d;
  logic [STRB_W-1:0]       strb_q, strb_d;
  logic                    err_q, err_d;

  logic [IDX_W-1:0]        idx_in;
  logic                    err_in;
  logic                    setup_seen;

  logic [RAM_AW-1:0]       ram_addr;
  logic [STRB_W-1:0]       ram_we;
  logic                    ram_re;
  logic                    ram_clr;
  logic [DATA_W-1:0]       ram_rdata;

  assign idx_in     = bus.paddr[ADDR_W-1:LSB];
  assign err_in     = ({1'b0, idx_in} >= IDX_LIMIT) || ((bus.paddr & ALIGN_MASK) != '0);
  assign setup_seen = bus.psel && !bus.penable;

  // Next-state and datapath control. The state register only ever holds IDLE
  // or ACCESS; the setup cycle is recognised here from the bus (psel without
  // penable while idle) and reported through 'phase', so back-to-back
  // transfers need no extra cycle between them.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    idx_d     = idx_q;
    write_d   = write_q;
    strb_d    = strb_q;
    err_d     = err_q;
    ram_addr  = idx_q;
    ram_we    = '0;
    ram_re    = 1'b0;
    ram_clr   = 1'b0;

    phase = state_q;
    if (state_q == IDLE && setup_seen) begin
      phase = SETUP;
    end

    case (phase)
      SETUP: begin
        idx_d     = idx_in[RAM_AW-1:0];
        write_d   = bus.pwrite;
        strb_d    = bus.pstrb;
        err_d     = err_in;
        cnt_d     = WAIT_INIT;
        pready_d  = NO_WAIT;
        pslverr_d = NO_WAIT ? err_in : APB_OKAY;
        state_d   = ACCESS;
        ram_addr  = idx_in[RAM_AW-1:0];
        if (!bus.pwrite) begin
          ram_clr = err_in;
          ram_re  = !err_in;
        end
      end
      ACCESS: begin
        if (pready_q) begin
          if (write_q && !err_q) begin
            ram_we = strb_q;
          end
          pready_d  = 1'b0;
          pslverr_d = APB_OKAY;
          state_d   = IDLE;
        end else if (!bus.psel) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
          if (cnt_q <= 1) begin
            pready_d  = 1'b1;
            pslverr_d = err_q ? APB_SLVERR : APB_OKAY;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset returns to IDLE with outputs low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= APB_OKAY;
      idx_q     <= '0;
      write_q   <= 1'b0;
      strb_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      idx_q     <= idx_d;
      write_q   <= write_d;
      strb_q    <= strb_d;
      err_q     <= err_d;
    end
  end

  // Reset blocks any commit and clears the read register that drives prdata.
  apb_mem_slave_ram #(
    .DEPTH    (DEPTH),
    .DATA_W   (DATA_W),
    .AW       (RAM_AW),
    .MEM_INIT (MEM_INIT)
  ) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (reset ? '0 : ram_we),
    .re    (ram_re && !reset),
    .clr   (ram_clr || reset),
    .wdata (bus.pwdata),
    .rdata (ram_rdata)
  );

  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;
  assign bus.prdata  = ram_rdata;

endmodule
